mult_fu_pipe: RTL and testbench
===============================

Name: mult_fu_pipe

Overview:
- Pipelined integer multiply functional unit. Sits directly downstream of the reservation station.
- Accepts at most one issued MULT instruction per cycle, with operands already read from the PRF.
- Computes the low XLEN bits of the unsigned product across NUM_STAGES pipeline stages.
- Requests the CDB to broadcast the result with its destination tag and ROB index.
- Stalls back-pressure to the RS when the CDB grant is withheld; squashes all in-flight work on a branch-mispredict flush.

Parameters:
XLEN, 64, operand and result width
NUM_STAGES, 4, pipeline depth; must divide XLEN evenly
TAG_W, 6, physical register tag width (PHYS_REG)
ROB_W, 5, ROB index width

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset (0 = reset)
flush  in  1  branch-mispredict squash
issue_valid  in  1  RS issues a MULT this cycle
issue_opa  in  XLEN  multiplicand
issue_opb  in  XLEN  multiplier
issue_tag  in  TAG_W  destination physical register
issue_rob  in  ROB_W  ROB index
fu_ready  out  1  stage 0 can accept an issue this cycle; feeds RS issue selection
cdb_req  out  1  final stage holds a valid result
cdb_grant  in  1  CDB arbiter accepts the result this cycle
cdb_value  out  XLEN  product, low XLEN bits
cdb_tag  out  TAG_W  destination tag
cdb_rob  out  ROB_W  ROB index

Behaviour:
- Clocking and reset:
  - All state updates on posedge clock.
  - reset==0 clears every stage valid bit and zeroes all payload registers.
  - Outputs after reset: cdb_req=0, cdb_value=0, cdb_tag=0, cdb_rob=0, fu_ready=1.
  - Reset dominates flush and issue, including mid-operation.
- Stage register s (0..NUM_STAGES-1) holds: valid, tag, rob, mcand, mplier, partial.
- Arithmetic:
  - Let CH = XLEN/NUM_STAGES.
  - Stage s adds (mcand << (s*CH)) * mplier[s*CH +: CH] to partial, modulo 2^XLEN.
  - Stage 0 loads partial = 0 plus its chunk contribution.
  - Overflow bits are discarded. Results are unsigned-low, so they are equal for signed two's-complement operands.
- Advance and stall rules:
  - adv[N-1] = valid[N-1] & cdb_grant.
  - adv[s] = valid[s] & (~valid[s+1] | adv[s+1]). Bubbles collapse; a stage moves forward whenever the next stage is empty or vacating.
  - A stage whose adv is 0 holds all fields unchanged.
  - A stage that vacates without being refilled clears its valid bit.
- Issue handshake:
  - fu_ready = ~valid[0] | adv[0], combinational in the same cycle.
  - Issue is accepted when issue_valid & fu_ready.
  - issue_valid while fu_ready==0 is a protocol violation: the issue is ignored and an assertion fires.
- Latency: NUM_STAGES cycles from the accepting edge to cdb_req=1 with no stall. With continuous grant, throughput is one result per cycle.
- CDB outputs:
  - cdb_req = valid[N-1]. cdb_value, cdb_tag and cdb_rob come directly from the stage N-1 registers.
  - While cdb_req & ~cdb_grant, all cdb_* outputs remain stable.
  - cdb_grant while cdb_req==0 is ignored.
- Flush:
  - At the edge where flush==1, all valid bits clear.
  - An issue in the same cycle is dropped.
  - Any result granted in the flush cycle is still considered broadcast.
  - On the next cycle cdb_req=0 and fu_ready=1.
- Full pipe with no grant: every stage is valid and stalled, so fu_ready=0 until the cycle in which a grant arrives.
- Simultaneous grant and issue with a full pipe: everything shifts by one and the new instruction enters stage 0 on the same edge.

Decomposition:
- Shared package (sys_defs): PHYS_REG typedef, XLEN, ROB index width, and a MULT_STAGE_T struct {valid, tag, rob, mcand, mplier, partial}.
- Sub-module mult_stage:
  - One combinational chunk multiply-accumulate plus its register with hold/clear controls.
  - Instantiated NUM_STAGES times with stage index as a parameter.
- Top level holds the advance chain, ready and flush logic.

Test Plan:
- Reset check: hold reset=0 for 2 cycles with issue_valid=1 -> cdb_req=0, fu_ready=1, no capture; release -> pipe empty.
- Single op: issue opa=3, opb=5, tag=12, rob=7, cdb_grant=1 -> exactly 4 cycles later cdb_req=1, value=15, tag=12, rob=7, held for one cycle only.
- Back-to-back and wrap-around: 4 consecutive issues (7*6, 0xFFFF_FFFF_FFFF_FFFF*2, 0x1_0000_0000*0x1_0000_0000, 0*9) with grant=1 -> results 42, 0xFFFF_FFFF_FFFF_FFFE, 0, 0 on consecutive cycles, in order.
- Stall and back-pressure: keep grant=0 while issuing 5 ops -> first 4 accepted, fu_ready=0 on the 5th attempt, cdb_* stable; raise grant for 1 cycle -> one result broadcast, fu_ready=1, 5th op enters the same edge.
- Flush mid-operation: issue 2 ops, assert flush 2 cycles later together with a third issue -> no cdb_req in the following 6 cycles, fu_ready=1, third op lost.
- Reset mid-operation during a stall with cdb_req=1 -> next cycle cdb_req=0, cdb_value=0; a subsequent issue of 9*9 returns 81 after 4 cycles.

Source files
------------

// File: rtl/mult_fu_pipe_pkg.sv
// Shared types and sizing for the pipelined multiply functional unit.
// The chunked multiply-accumulate helper is kept here so every stage uses one definition.
package mult_fu_pipe_pkg;

    localparam int XLEN       = 64;
    localparam int NUM_STAGES = 4;
    localparam int TAG_W      = 6;
    localparam int ROB_W      = 5;

    typedef logic [TAG_W-1:0] PHYS_REG;
    typedef logic [ROB_W-1:0] ROB_IDX;

    typedef struct packed {
        logic            valid;
        PHYS_REG         tag;
        ROB_IDX          rob;
        logic [XLEN-1:0] mcand;
        logic [XLEN-1:0] mplier;
        logic [XLEN-1:0] partial;
    } MULT_STAGE_T;

    // partial + (mcand << sh) * mplier[sh +: ch], truncated to XLEN bits
    function automatic logic [XLEN-1:0] chunk_mac(
        input logic [XLEN-1:0] partial,
        input logic [XLEN-1:0] mcand,
        input logic [XLEN-1:0] mplier,
        input int unsigned     sh,
        input int unsigned     ch
    );
        logic [XLEN-1:0] mask;
        logic [XLEN-1:0] digit;
        mask  = (XLEN'(1) << ch) - XLEN'(1);
        digit = (mplier >> sh) & mask;
        return partial + ((mcand << sh) * digit);
    endfunction

endpackage

// File: rtl/mult_fu_pipe_if.sv
// Issue and CDB signals between the RS/CDB arbiter (master) and the multiply unit (slave).
interface mult_fu_pipe_if;
    import mult_fu_pipe_pkg::*;

    logic            issue_valid;
    logic [XLEN-1:0] issue_opa;
    logic [XLEN-1:0] issue_opb;
    PHYS_REG         issue_tag;
    ROB_IDX          issue_rob;
    logic            fu_ready;

    logic            cdb_req;
    logic            cdb_grant;
    logic [XLEN-1:0] cdb_value;
    PHYS_REG         cdb_tag;
    ROB_IDX          cdb_rob;

    modport master (
        output issue_valid, issue_opa, issue_opb, issue_tag, issue_rob, cdb_grant,
        input  fu_ready, cdb_req, cdb_value, cdb_tag, cdb_rob
    );

    modport slave (
        input  issue_valid, issue_opa, issue_opb, issue_tag, issue_rob, cdb_grant,
        output fu_ready, cdb_req, cdb_value, cdb_tag, cdb_rob
    );

endinterface

// File: rtl/mult_fu_pipe_stage.sv
// One multiply pipeline stage: adds this stage's multiplier chunk product to the
// incoming partial and registers the result, with hold / vacate / flush control.
module mult_stage
    import mult_fu_pipe_pkg::*;
#(
    parameter int STAGE = 0,
    parameter int CH    = XLEN / NUM_STAGES
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic        load,
    input  logic        vacate,
    input  MULT_STAGE_T src,
    output MULT_STAGE_T q
);

    MULT_STAGE_T nxt;

    always_comb begin
        nxt         = src;
        nxt.partial = chunk_mac(src.partial, src.mcand, src.mplier, STAGE * CH, CH);
    end

    // load wins over vacate: a stage emptying and being refilled on the same edge takes the new op
    always_ff @(posedge clock) begin
        if (!reset) begin
            q <= '0;
        end else if (flush) begin
            q.valid <= 1'b0;
        end else if (load) begin
            q <= nxt;
        end else if (vacate) begin
            q.valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mult_fu_pipe.sv
// Pipelined unsigned-low integer multiplier feeding the CDB. Holds the advance
// chain, issue readiness and flush handling around an array of mult_stage.
module mult_fu_pipe
    import mult_fu_pipe_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    input  logic          flush,
    mult_fu_pipe_if.slave bus
);

    MULT_STAGE_T           st  [NUM_STAGES];
    MULT_STAGE_T           src [NUM_STAGES];
    logic [NUM_STAGES-1:0] vld;
    logic [NUM_STAGES-1:0] adv;
    logic [NUM_STAGES-1:0] load;
    logic                  accept;

    // Resolved from the tail backwards so a bubble anywhere lets everything behind it move up
    always_comb begin
        adv                 = '0;
        adv[NUM_STAGES-1]   = vld[NUM_STAGES-1] & bus.cdb_grant;
        for (int s = NUM_STAGES - 2; s >= 0; s--) begin
            adv[s] = vld[s] & (~vld[s+1] | adv[s+1]);
        end
    end

    assign bus.fu_ready = ~vld[0] | adv[0];
    assign accept       = bus.issue_valid & bus.fu_ready & ~flush;

    always_comb begin
        src[0]         = '0;
        src[0].valid   = 1'b1;
        src[0].tag     = bus.issue_tag;
        src[0].rob     = bus.issue_rob;
        src[0].mcand   = bus.issue_opa;
        src[0].mplier  = bus.issue_opb;
        src[0].partial = '0;
        load[0]        = accept;
        for (int s = 1; s < NUM_STAGES; s++) begin
            src[s]  = st[s-1];
            load[s] = adv[s-1];
        end
    end

    for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
        mult_stage #(.STAGE(s)) u_stage (
            .clock  (clock),
            .reset  (reset),
            .flush  (flush),
            .load   (load[s]),
            .vacate (adv[s]),
            .src    (src[s]),
            .q      (st[s])
        );
        assign vld[s] = st[s].valid;
    end

    assign bus.cdb_req   = vld[NUM_STAGES-1];
    assign bus.cdb_value = st[NUM_STAGES-1].partial;
    assign bus.cdb_tag   = st[NUM_STAGES-1].tag;
    assign bus.cdb_rob   = st[NUM_STAGES-1].rob;

    // The RS must only issue when fu_ready is high
    always @(posedge clock) begin
        if (reset && bus.issue_valid) begin
            a_issue_when_ready: assert (bus.fu_ready);
        end
    end

endmodule

// File: tb/tb_mult_fu_pipe.sv
// Scoreboard bench for mult_fu_pipe: issued ops are pushed with their arithmetic
// product; a negedge monitor checks every CDB presentation against the queue head.
module tb_mult_fu_pipe;
    import mult_fu_pipe_pkg::*;

    typedef struct {
        logic [XLEN-1:0] value;
        PHYS_REG         tag;
        ROB_IDX          rob;
    } exp_t;

    logic clk   = 1'b0;
    logic rst   = 1'b0;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    mult_fu_pipe_if bus ();

    mult_fu_pipe dut (
        .clock (clk),
        .reset (rst),
        .flush (flush),
        .bus   (bus.slave)
    );

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: whatever the CDB shows must be the oldest surviving op, held until granted
    always @(negedge clk) begin
        if (!rst) begin
            q.delete();
        end else begin
            if (bus.cdb_req) begin
                if (q.size() == 0) begin
                    check("cdb_req_unexpected", XLEN'(bus.cdb_req), '0);
                end else begin
                    check("cdb_value", bus.cdb_value, q[0].value);
                    check("cdb_tag", XLEN'(bus.cdb_tag), XLEN'(q[0].tag));
                    check("cdb_rob", XLEN'(bus.cdb_rob), XLEN'(q[0].rob));
                    if (bus.cdb_grant) void'(q.pop_front());
                end
            end
            if (flush) q.delete();
        end
    end

    // One cycle of stimulus. Pipe occupancy model: the unit refuses an issue only
    // when all stages hold ops and nothing leaves this cycle.
    task automatic step(input logic rs, input logic iv, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input PHYS_REG t, input ROB_IDX r, input logic g, input logic fl, output logic acc);
        exp_t e;
        @(posedge clk);
        #1;
        rst             = rs;
        bus.issue_valid = iv;
        bus.issue_opa   = a;
        bus.issue_opb   = b;
        bus.issue_tag   = t;
        bus.issue_rob   = r;
        bus.cdb_grant   = g;
        flush           = fl;
        #1;
        if (rs) check("fu_ready", XLEN'(bus.fu_ready), (q.size() >= NUM_STAGES && !g) ? '0 : XLEN'(1));
        acc = iv && bus.fu_ready && rs && !fl;
        if (iv && !bus.fu_ready) bus.issue_valid = 1'b0;
        if (acc) begin
            e.value = a * b;
            e.tag   = t;
            e.rob   = r;
            q.push_back(e);
        end
    endtask

    task automatic idle(input logic g);
        logic acc;
        step(1'b1, 1'b0, '0, '0, '0, '0, g, 1'b0, acc);
    endtask

    task automatic issue(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input PHYS_REG t,
                         input ROB_IDX r, input logic g, output logic acc);
        step(1'b1, 1'b1, a, b, t, r, g, 1'b0, acc);
    endtask

    logic [XLEN-1:0] bb_a [4];
    logic [XLEN-1:0] bb_b [4];

    initial begin
        logic acc;
        bb_a = '{64'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1_0000_0000, 64'd0};
        bb_b = '{64'd6, 64'd2, 64'h1_0000_0000, 64'd9};

        bus.issue_valid = 1'b0;
        bus.issue_opa   = '0;
        bus.issue_opb   = '0;
        bus.issue_tag   = '0;
        bus.issue_rob   = '0;
        bus.cdb_grant   = 1'b0;

        // Reset held with an issue present: nothing captured, outputs zero
        step(1'b0, 1'b1, 64'd5, 64'd5, 6'd1, 5'd1, 1'b1, 1'b0, acc);
        step(1'b0, 1'b1, 64'd5, 64'd5, 6'd1, 5'd1, 1'b1, 1'b0, acc);
        check("rst_cdb_req", XLEN'(bus.cdb_req), '0);
        check("rst_fu_ready", XLEN'(bus.fu_ready), XLEN'(1));
        check("rst_cdb_value", bus.cdb_value, '0);
        check("rst_cdb_tag", XLEN'(bus.cdb_tag), '0);
        check("rst_cdb_rob", XLEN'(bus.cdb_rob), '0);
        for (int i = 0; i < 6; i++) begin
            idle(1'b1);
            check("post_rst_empty", XLEN'(bus.cdb_req), '0);
        end

        // Single op: result appears exactly NUM_STAGES cycles after issue, for one cycle
        issue(64'd3, 64'd5, 6'd12, 5'd7, 1'b1, acc);
        check("single_acc", XLEN'(acc), XLEN'(1));
        for (int i = 1; i <= 6; i++) begin
            idle(1'b1);
            check("single_req_timing", XLEN'(bus.cdb_req), (i == NUM_STAGES) ? XLEN'(1) : '0);
            if (i == NUM_STAGES) check("single_value", bus.cdb_value, 64'd15);
        end

        // Back-to-back with wrap-around products
        for (int i = 0; i < 4; i++) issue(bb_a[i], bb_b[i], PHYS_REG'(20 + i), ROB_IDX'(i), 1'b1, acc);
        for (int i = 1; i <= 6; i++) begin
            idle(1'b1);
            check("b2b_req", XLEN'(bus.cdb_req), (i <= 4) ? XLEN'(1) : '0);
        end

        // Stall: fill with no grant, fifth refused, one grant lets it in on the same edge
        for (int i = 0; i < 4; i++) begin
            issue(64'(100 + i), 64'(3 + i), PHYS_REG'(30 + i), ROB_IDX'(10 + i), 1'b0, acc);
            check("stall_fill_acc", XLEN'(acc), XLEN'(1));
        end
        issue(64'd77, 64'd11, 6'd40, 5'd20, 1'b0, acc);
        check("stall_5th_refused", XLEN'(acc), '0);
        for (int i = 0; i < 3; i++) idle(1'b0);
        issue(64'd77, 64'd11, 6'd40, 5'd20, 1'b1, acc);
        check("stall_5th_enters", XLEN'(acc), XLEN'(1));
        idle(1'b0);
        idle(1'b0);
        for (int i = 0; i < 10 && q.size() != 0; i++) idle(1'b1);

        // Flush mid-operation together with a third issue
        issue(64'd21, 64'd2, 6'd50, 5'd1, 1'b1, acc);
        issue(64'd22, 64'd2, 6'd51, 5'd2, 1'b1, acc);
        idle(1'b1);
        step(1'b1, 1'b1, 64'd23, 64'd2, 6'd52, 5'd3, 1'b1, 1'b1, acc);
        for (int i = 0; i < 6; i++) begin
            idle(1'b1);
            check("flush_no_req", XLEN'(bus.cdb_req), '0);
        end

        // Reset while a stalled result is on the CDB
        issue(64'd11, 64'd13, 6'd60, 5'd4, 1'b0, acc);
        for (int i = 0; i < 10 && !bus.cdb_req; i++) idle(1'b0);
        check("stalled_req_seen", XLEN'(bus.cdb_req), XLEN'(1));
        step(1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0, acc);
        idle(1'b0);
        check("midrst_req", XLEN'(bus.cdb_req), '0);
        check("midrst_value", bus.cdb_value, '0);
        issue(64'd9, 64'd9, 6'd61, 5'd5, 1'b1, acc);
        for (int i = 1; i <= NUM_STAGES; i++) idle(1'b1);
        check("post_rst_req", XLEN'(bus.cdb_req), XLEN'(1));
        check("post_rst_value", bus.cdb_value, 64'd81);
        idle(1'b1);

        // Randomized traffic with back-pressure and occasional flushes
        for (int i = 0; i < 400; i++) begin
            logic [XLEN-1:0] a, b;
            a = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 15)) : {$urandom, $urandom};
            b = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 15)) : {$urandom, $urandom};
            step(1'b1, 1'($urandom_range(0, 1)), a, b, PHYS_REG'($urandom), ROB_IDX'($urandom),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0), acc);
        end

        for (int i = 0; i < 40 && q.size() != 0; i++) idle(1'b1);
        check("drain_left", XLEN'(q.size()), '0);
        idle(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
